// File: rtl/uart_tx_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states, frame sizes, defaults.
// Optional even-parity bit is compiled in with macro UART_TX_PARITY_EN.
package uart_tx_pkg;

  localparam int DEFAULT_DIV   = 16;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DATA_BITS     = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

  // Line-time of one complete frame for a given bit period.
  function automatic int frame_cycles(input int div);
    return FRAME_BITS * div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and wrapping pointers.
// Read data is the head entry, valid whenever the FIFO is non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  // Storage is deliberately left out of reset; only the bookkeeping clears.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte-queued UART transmitter: 8N1 frames (8E1 with UART_TX_PARITY_EN), DIV clocks per bit.
// Frames leave back-to-back while bytes remain queued.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DIV   = DEFAULT_DIV,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  tx_state_e   state_reg, state_next;
  logic [15:0] div_cnt_reg, div_cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  data_reg, data_next;
  logic        tx_reg, tx_next;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [7:0]  rd_data;
  logic        bit_done;

  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  assign bit_done = (div_cnt_reg == DIV_LAST);

  // tx is computed for the state being entered so the line is a clean register output.
  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg + 16'd1;
    bit_idx_next = bit_idx_reg;
    data_next    = data_reg;
    tx_next      = tx_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        div_cnt_next = '0;
        tx_next      = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          data_next  = rd_data;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          div_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = DATA;
          tx_next      = data_reg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          div_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = ^data_reg;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = data_reg[bit_idx_reg + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          div_cnt_next = '0;
          state_next   = STOP;
          tx_next      = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          div_cnt_next = '0;
          if (!empty) begin
            pop        = 1'b1;
            data_next  = rd_data;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        div_cnt_next = '0;
        state_next   = IDLE;
        tx_next      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      bit_idx_reg <= '0;
      data_reg    <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      bit_idx_reg <= bit_idx_next;
      data_reg    <= data_next;
      tx_reg      <= tx_next;
    end
  end

  assign tx   = tx_reg;
  assign busy = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DIV, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  meaning sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port in_data  input  8  meaning byte to transmit.
REQ-006 SHALL have port in_valid  input  1  meaning in_data is offered.
REQ-007 SHALL have port in_ready  output  1  meaning FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  meaning serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  meaning FIFO non-empty or frame in progress.
REQ-010 SHALL have port fifo_count  output  $clog2(DEPTH)+1  meaning bytes queued, not yet popped.

Function
REQ-011 SHALL accept a byte on every rising edge where in_valid && in_ready; in_ready = !full && !rst, combinational.
REQ-012 SHALL keep in_data unsampled and FIFO unchanged when in_valid && !in_ready; no overwrite when full.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL, in IDLE with FIFO non-empty, pop one byte and enter START on the same edge; tx goes low one cycle after the handshake cycle for an empty, idle block.
REQ-015 SHALL hold each bit for exactly DIV cycles using a bit-period counter reset on every state entry.
REQ-016 SHALL send START (0), then DATA bits LSB first (3-bit index 0..7), then PARITY if enabled, then STOP (1) for DIV cycles.
REQ-017 SHALL, at the end of STOP, enter START directly with no idle cycle if FIFO non-empty, else IDLE.
REQ-018 SHALL allow a push and a pop on the same edge; fifo_count then stays unchanged.
REQ-019 SHALL wrap read/write pointers modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-020 SHALL drive busy = (state != IDLE) || (fifo_count != 0), registered-equivalent timing to state.

Reset
REQ-021 SHALL, on any edge with rst high, force tx=1, state=IDLE, fifo_count=0, pointers=0, bit counters=0, busy=0.
REQ-022 SHALL abort a frame in progress on reset; tx returns high the cycle after rst is sampled; queued bytes are discarded.
REQ-023 SHALL hold in_ready low while rst is high; FIFO contents are not reset (only pointers).

Configuration
REQ-024 SHALL, with macro UART_TX_PARITY_EN defined, insert PARITY state carrying even parity (XOR of 8 data bits) between DATA and STOP; frame = 11*DIV cycles.
REQ-025 SHALL, without UART_TX_PARITY_EN, omit PARITY state and logic entirely; DATA goes to STOP; frame = 10*DIV cycles.

Structure
REQ-026 SHALL place the FSM state enum, frame-length constants and default DIV/DEPTH in shared package uart_tx_pkg.
REQ-027 SHALL implement storage as one sub-module sync_fifo (parameterised width 8, DEPTH), instantiated once; serializer and FSM live in uart_tx_fifo.

Verification (DIV=4, DEPTH=4 unless stated)
REQ-028 SHALL cover: reset, then push 0xA5 once -> tx low 1 cycle later, line reads 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, busy low after 40 cycles.
REQ-029 SHALL cover: push 0x00,0xFF,0x55 back-to-back -> three contiguous frames, no idle cycle between stop and next start, total 120 cycles busy.
REQ-030 SHALL cover: hold in_valid high with 6 bytes while first frame runs -> in_ready drops when fifo_count=4, no byte lost or duplicated, all 6 transmitted in order.
REQ-031 SHALL cover: assert rst for 1 cycle at bit 3 of a frame with 2 bytes queued -> tx=1 next cycle, fifo_count=0, busy=0, no further frames.
REQ-032 SHALL cover: with UART_TX_PARITY_EN, push 0x07 -> parity bit 1, frame 44 cycles; push 0x03 -> parity bit 0.
REQ-033 SHALL cover: push and pop on same edge with fifo_count=2 -> fifo_count remains 2.
